// File: rtl/led_arbiter.sv
// Shares four status LEDs between four requesters: round-robin grant, minimum hold time, optional blink gating.
// Latency: grant and led are registered, so they appear one cycle after req is sampled; a handoff takes 3 cycles.
// No backpressure: req is a level, and a requester keeps asking until it sees its grant bit.
module led_arbiter #(
  parameter int TICK_DIV    = 32000,
  parameter int HOLD_TICKS  = 500,
  parameter int BLINK_TICKS = 250,
  parameter bit FAIR        = 1'b1,
  parameter bit IDLE_BLINK  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] pattern,
  input  logic [3:0]  blink,
  output logic [3:0]  grant,
  output logic [3:0]  led,
  output logic        tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_FULL  = HW'(HOLD_TICKS);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      rr_q, rr_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick_q, tick_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      grant_q, grant_d;
  logic [3:0]      led_q, led_d;

  logic [1:0]      win;
  logic            expired;
  logic            others_wait;
  logic            release_own;
  logic [3:0]      heartbeat;

  // First requesting index found when scanning upward from the pointer, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] idx;
    w = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  // Owner's nibble, blanked during the dark half of the blink phase when that owner asked for blinking.
  function automatic logic [3:0] owner_leds(input logic [15:0] pat, input logic [3:0] blk,
                                            input logic [1:0] o, input logic ph);
    logic [15:0] sh;
    sh = pat >> {o, 2'b00};
    return sh[3:0] & {4{ph | ~blk[o]}};
  endfunction

  // Prescaler: tick pulses the cycle after the divider wraps; phase flips every BLINK_TICKS ticks.
  always_comb begin
    tick_cnt_d  = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    tick_d      = (tick_cnt_q == TICK_LAST);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Arbitration terms; the LED image uses next-cycle phase so the registered led lines up with phase.
  always_comb begin
    win         = rr_pick(req, rr_q);
    expired     = (hold_q == HOLD_FULL);
    others_wait = |(req & ~grant_q);
    release_own = expired && (!req[owner_q] || (FAIR && others_wait));
    heartbeat   = IDLE_BLINK ? {4{phase_d}} : 4'b0000;
  end

  // Ownership FSM: IDLE grants, OWN holds for the minimum time, GAP blanks for one cycle between owners.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    grant_d = 4'b0000;
    led_d   = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        led_d = heartbeat;
        if (|req) begin
          state_d = ST_OWN;
          owner_d = win;
          hold_d  = '0;
          grant_d = 4'b0001 << win;
          led_d   = owner_leds(pattern, blink, win, phase_d);
        end
      end
      ST_OWN: begin
        if (release_own) begin
          state_d = ST_GAP;
          rr_d    = owner_q + 2'd1;
        end else begin
          if (tick_q && !expired) hold_d = hold_q + HW'(1);
          grant_d = grant_q;
          led_d   = owner_leds(pattern, blink, owner_q, phase_d);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        led_d   = heartbeat;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset wins over everything, including an active ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'd0;
      rr_q        <= 2'd0;
      tick_cnt_q  <= '0;
      tick_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      hold_q      <= '0;
      grant_q     <= 4'b0000;
      led_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      tick_cnt_q  <= tick_cnt_d;
      tick_q      <= tick_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      led_q       <= led_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign tick  = tick_q;

endmodule
